// File: rtl/text_tile_fetch_if.sv
// Raster-side and video-memory-side signals of the text tile fetcher.
interface text_tile_fetch_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        de;
   logic        hsync_in;
   logic        vsync_in;
   logic [14:0] mem_addr;
   logic [7:0]  mem_data;
   logic        pixel_on;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;

   modport master (
      output x, y, de, hsync_in, vsync_in, mem_data,
      input  mem_addr, pixel_on, de_out, hsync_out, vsync_out
   );

   modport slave (
      input  x, y, de, hsync_in, vsync_in, mem_data,
      output mem_addr, pixel_on, de_out, hsync_out, vsync_out
   );
endinterface

// File: rtl/text_tile_fetch.sv
// Text-mode tile fetcher: char map -> font row -> 1-bit pixel stream,
// with timing re-aligned to a fixed 8-cycle latency.
module text_tile_fetch #(
   parameter logic [14:0] MAP_BASE  = 15'h0000,
   parameter logic [14:0] FONT_BASE = 15'h1400
) (
   input logic            clk,
   input logic            rst_n,
   text_tile_fetch_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CHAR_WAIT,
      CHAR_CAP,
      FONT_WAIT,
      FONT_CAP
   } state_e;

   state_e      state_q, state_d;
   logic [14:0] addr_q, addr_d;
   logic [2:0]  row_q, row_d;
   logic        inv_q, inv_d;
   logic        valid_q, valid_d;
   logic [7:0]  pend_q, pend_d;
   logic [7:0]  shift_q, shift_d;
   logic        pix_q, pix_d;
   logic [7:0]  de_sr_q, hs_sr_q, vs_sr_q;
   logic        de_out_q, hs_out_q, vs_out_q;

   logic        tile_edge;
   logic        in_range;
   logic        start;
   logic [14:0] line_w;
   logic [14:0] char_addr;
   logic [14:0] font_addr;

   assign tile_edge = (bus.x[2:0] == 3'd0);
   assign in_range  = (bus.x < 10'd640) && (bus.y < 10'd480);
   assign start     = bus.de && tile_edge && in_range;

   // line*80 as two shifts; everything wraps at 15 bits
   assign line_w    = {9'd0, bus.y[8:3]};
   assign char_addr = MAP_BASE + (line_w << 6) + (line_w << 4)
                    + {8'd0, bus.x[9:3]};
   assign font_addr = FONT_BASE + {5'd0, bus.mem_data[6:0], row_q};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      inv_d   = inv_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      shift_d = {shift_q[6:0], 1'b0};
      pix_d   = shift_q[6];

      unique case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = bus.y[2:0];
               addr_d  = char_addr;
               state_d = CHAR_WAIT;
            end
         end
         CHAR_WAIT: state_d = CHAR_CAP;
         CHAR_CAP: begin
            inv_d   = bus.mem_data[7];
            addr_d  = font_addr;
            state_d = FONT_WAIT;
         end
         FONT_WAIT: state_d = FONT_CAP;
         FONT_CAP: begin
            pend_d  = bus.mem_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // tile boundary: hand the completed fetch to the serialiser
      if (tile_edge) begin
         shift_d = valid_q ? (pend_q ^ {8{inv_q}}) : 8'h00;
         pix_d   = shift_d[7];
         valid_d = 1'b0;
      end
      if (state_q == FONT_CAP) valid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         row_q    <= '0;
         inv_q    <= 1'b0;
         valid_q  <= 1'b0;
         pend_q   <= '0;
         shift_q  <= '0;
         pix_q    <= 1'b0;
         de_sr_q  <= '0;
         hs_sr_q  <= '1;
         vs_sr_q  <= '1;
         de_out_q <= 1'b0;
         hs_out_q <= 1'b1;
         vs_out_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         row_q    <= row_d;
         inv_q    <= inv_d;
         valid_q  <= valid_d;
         pend_q   <= pend_d;
         shift_q  <= shift_d;
         pix_q    <= pix_d;
         de_sr_q  <= {de_sr_q[6:0], bus.de};
         hs_sr_q  <= {hs_sr_q[6:0], bus.hsync_in};
         vs_sr_q  <= {vs_sr_q[6:0], bus.vsync_in};
         de_out_q <= de_sr_q[7];
         hs_out_q <= hs_sr_q[7];
         vs_out_q <= vs_sr_q[7];
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.pixel_on  = pix_q;
   assign bus.de_out    = de_out_q;
   assign bus.hsync_out = hs_out_q;
   assign bus.vsync_out = vs_out_q;

endmodule

// File: tb/tb_text_tile_fetch.sv
// Bench for text_tile_fetch: directed cases plus randomised raster
// checked every cycle against a per-tile behavioural model.
module tb_text_tile_fetch;

   localparam logic [14:0] MAP_BASE  = 15'h0000;
   localparam logic [14:0] FONT_BASE = 15'h1400;
   localparam int NMAX = 65536;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   text_tile_fetch_if ifc ();

   text_tile_fetch #(
      .MAP_BASE (MAP_BASE),
      .FONT_BASE(FONT_BASE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   logic [7:0] mem [0:32767];
   always @(posedge clk) ifc.mem_data <= mem[ifc.mem_addr];

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] hx [NMAX];
   logic [9:0] hy [NMAX];
   logic       hde [NMAX];
   logic       hhs [NMAX];
   logic       hvs [NMAX];
   int n = 0;
   int rst_mark = 0;

   int rx = 0;
   int ry = 0;
   int lw = 656;
   int ymax = 525;
   logic [14:0] exp_addr = '0;
   logic [14:0] prev_addr = '0;
   logic cnt_on = 1'b0;
   int addr_chg = 0;
   int starts = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
      end
   endtask

   function automatic logic [14:0] char_a(input int x, input int y);
      return MAP_BASE + 15'((y / 8) * 80 + x / 8);
   endfunction

   function automatic logic [14:0] font_a(input int x, input int y);
      logic [7:0] c;
      c = mem[char_a(x, y)];
      return FONT_BASE + 15'(int'(c[6:0]) * 8 + y % 8);
   endfunction

   function automatic logic is_start(input int i);
      if (i < rst_mark || i < 0) return 1'b0;
      return hde[i] && hx[i] < 640 && hy[i] < 480 && hx[i] % 8 == 0;
   endfunction

   // pixel k of a tile is lit only if the tile's first sample started a fetch
   function automatic logic exp_pix(input int m);
      int k, s;
      logic [7:0] c, f;
      k = int'(hx[m]) % 8;
      s = m - k;
      if (s < rst_mark) return 1'b0;
      if (!is_start(s) || int'(hx[s]) != int'(hx[m]) - k) return 1'b0;
      c = mem[char_a(hx[s], hy[s])];
      f = mem[font_a(hx[s], hy[s])];
      if (c[7]) f = ~f;
      return f[7-k];
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pix"}, ifc.pixel_on, 0);
      chk({tag, "_de"}, ifc.de_out, 0);
      chk({tag, "_hs"}, ifc.hsync_out, 1);
      chk({tag, "_vs"}, ifc.vsync_out, 1);
   endtask

   task automatic tick(input logic d, input logic hs, input logic vs);
      logic rec;
      int e, m;
      ifc.x = 10'(rx);
      ifc.y = 10'(ry);
      ifc.de = d;
      ifc.hsync_in = hs;
      ifc.vsync_in = vs;
      @(posedge clk);
      rec = rst_n;
      e = n;
      if (rec) begin
         if (e >= NMAX) begin
            $display("FAIL history_overflow: got %0d expected <%0d", e, NMAX);
            $fatal(1, "history overflow");
         end
         hx[e] = ifc.x;
         hy[e] = ifc.y;
         hde[e] = d;
         hhs[e] = hs;
         hvs[e] = vs;
         n++;
      end
      #1;
      if (!rec) begin
         exp_addr = '0;
         chk_reset_vals("in_reset");
         chk("in_reset_addr", ifc.mem_addr, 0);
      end else begin
         if (is_start(e)) begin
            exp_addr = char_a(hx[e], hy[e]);
            if (cnt_on) starts++;
         end
         if (is_start(e - 2)) exp_addr = font_a(hx[e-2], hy[e-2]);
         m = e - 8;
         if (m < rst_mark) begin
            chk_reset_vals("pipe_fill");
         end else begin
            chk("de_out", ifc.de_out, hde[m]);
            chk("hsync_out", ifc.hsync_out, hhs[m]);
            chk("vsync_out", ifc.vsync_out, hvs[m]);
            chk("pixel_on", ifc.pixel_on, exp_pix(m));
         end
         chk("mem_addr", ifc.mem_addr, exp_addr);
      end
      if (cnt_on && ifc.mem_addr !== prev_addr) addr_chg++;
      prev_addr = ifc.mem_addr;
      rx++;
      if (rx == lw) begin
         rx = 0;
         ry++;
         if (ry == ymax) ry = 0;
      end
   endtask

   task automatic run(input int cyc);
      for (int i = 0; i < cyc; i++)
         tick(rx < 640 && ry < 480, !(rx >= 644 && rx < 648),
              !(ry >= 490 && ry < 492));
   endtask

   task automatic align();
      while (rx % 8 != 0) run(1);
   endtask

   initial begin
      logic [7:0] pat;
      logic [14:0] a0;
      int cx, cy;

      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h41;
      mem[15'h1608] = 8'hA5;
      mem[81] = 8'hC1;

      // power-on reset
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("por");
      chk("por_addr", ifc.mem_addr, 0);
      for (int i = 0; i < 4; i++)
         tick(1'($urandom), 1'($urandom), 1'($urandom));
      rst_n = 1'b1;

      // tile (0,0): glyph 0x41 row 0, font byte A5
      rx = 0;
      ry = 0;
      run(1);
      chk("b_addr_e0", ifc.mem_addr, 15'h0000);
      run(2);
      chk("b_addr_e2", ifc.mem_addr, 15'h1608);
      run(5);
      chk("b_de_out_e7", ifc.de_out, 0);
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         run(1);
         chk("b_pix", ifc.pixel_on, pat[7-i]);
         if (i == 0) chk("b_de_out_e8", ifc.de_out, 1);
      end

      // inverted glyph at line 1, row 2, col 1
      align();
      rx = 8;
      ry = 10;
      run(1);
      chk("c_char_addr", ifc.mem_addr, 15'h0051);
      run(2);
      chk("c_font_addr", ifc.mem_addr, 15'h160A);
      run(5);
      pat = ~mem[15'h160A];
      for (int i = 0; i < 8; i++) begin
         run(1);
         chk("c_pix_inv", ifc.pixel_on, pat[7-i]);
      end

      // reset asserted at E3 of a fetch, released after E5
      align();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
      rst_mark = n;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("d_async");
      chk("d_async_addr", ifc.mem_addr, 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
      rst_n = 1'b1;
      while (rx % 8 != 0) begin
         tick(1'b1, 1'b0, 1'b1);
         chk("d_hs_after_rst", ifc.hsync_out, 1);
      end
      cx = rx;
      cy = ry;
      tick(1'b1, 1'b0, 1'b1);
      chk("d_resume_addr", ifc.mem_addr, char_a(cx, cy));
      chk("d_bg_pix", ifc.pixel_on, 0);
      for (int i = 0; i < 7; i++) begin
         tick(1'b1, 1'b0, 1'b1);
         chk("d_bg_pix", ifc.pixel_on, 0);
      end
      run(8);

      // de rising mid-tile at x%8==3
      align();
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
      a0 = ifc.mem_addr;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         chk("e_no_read", ifc.mem_addr, a0);
      end
      cx = rx;
      cy = ry;
      tick(1'b1, 1'b1, 1'b1);
      chk("e_read_at_8", ifc.mem_addr, char_a(cx, cy));
      chk("e_partial_pix", ifc.pixel_on, 0);
      for (int i = 0; i < 7; i++) begin
         run(1);
         chk("e_partial_pix", ifc.pixel_on, 0);
      end
      run(8);

      // random de/syncs, crossing y=480 and x>=640
      align();
      rx = 0;
      ry = 472;
      lw = 672;
      for (int i = 0; i < 15000; i++)
         tick($urandom % 4 != 0, $urandom % 8 != 0, $urandom % 16 != 0);

      // 60 fully enabled lines of the frame
      align();
      rx = 0;
      ry = 0;
      lw = 656;
      prev_addr = ifc.mem_addr;
      addr_chg = 0;
      starts = 0;
      cnt_on = 1'b1;
      run(60 * 656);
      cnt_on = 1'b0;
      chk("g_addr_changes", addr_chg, 9600);
      chk("g_addr_per_tile", addr_chg, 2 * starts);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
